// File: rtl/sr_ctrl_pkg.sv
// rtl/sr_ctrl_pkg.sv - state encodings, SR codes and excitation helper for sr_counter_ctrl
package sr_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam logic [1:0] SR_HOLD    = 2'b00;
  localparam logic [1:0] SR_RST     = 2'b01;
  localparam logic [1:0] SR_SET     = 2'b10;
  localparam logic [1:0] SR_ILLEGAL = 2'b11;

  // Returns {s,r}; by construction never yields SR_ILLEGAL.
  function automatic logic [1:0] sr_excite(input logic next_bit, input logic cur_bit);
    if (next_bit && !cur_bit)
      return SR_SET;
    else if (!next_bit && cur_bit)
      return SR_RST;
    else
      return SR_HOLD;
  endfunction

endpackage

// File: rtl/sr_counter_ctrl_bank.sv
// rtl/sr_counter_ctrl_bank.sv - sr_reg_bank: WIDTH SR flip-flops with async active-low clear
module sr_reg_bank
  import sr_ctrl_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        case ({s[i], r[i]})
          SR_SET:  q[i] <= 1'b1;
          SR_RST:  q[i] <= 1'b0;
          default: q[i] <= q[i];
        endcase
      end
    end
  end

endmodule

// File: rtl/sr_counter_ctrl.sv
// rtl/sr_counter_ctrl.sv - up/down modulo counter controller driving an SR flop bank
// Optional wrap counter output enabled by SR_CTRL_WRAP_CNT_EN.
module sr_counter_ctrl
  import sr_ctrl_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             stop,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dir,
  input  logic [WIDTH-1:0] mod_val,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             paused,
  output logic             tc
`ifdef SR_CTRL_WRAP_CNT_EN
  , output logic [7:0]     wrap_cnt
`endif
);

  state_t           state, state_nx;
  logic [WIDTH-1:0] next_count;
  logic [WIDTH-1:0] clamp_val;
  logic [WIDTH-1:0] step_val;
  logic             step_wrap;
  logic             tc_nx;
  logic [WIDTH-1:0] s, r;

  assign clamp_val = (load_val > mod_val) ? mod_val : load_val;

  // Out-of-range counts (after a mod_val change) wrap like a terminal count.
  always_comb begin
    step_val  = count;
    step_wrap = 1'b0;
    if (dir) begin
      if (count >= mod_val) begin
        step_val  = '0;
        step_wrap = 1'b1;
      end else begin
        step_val = count + WIDTH'(1);
      end
    end else begin
      if (count == '0 || count > mod_val) begin
        step_val  = mod_val;
        step_wrap = 1'b1;
      end else begin
        step_val = count - WIDTH'(1);
      end
    end
  end

  always_comb begin
    state_nx   = state;
    next_count = count;
    tc_nx      = 1'b0;
    case (state)
      IDLE: begin
        if (load)
          next_count = clamp_val;
        else if (!stop && start)
          state_nx = RUN;
      end
      RUN: begin
        if (load) begin
          next_count = clamp_val;
        end else if (stop) begin
          state_nx = PAUSE;
        end else begin
          next_count = step_val;
          tc_nx      = step_wrap;
        end
      end
      PAUSE: begin
        if (load) begin
          next_count = clamp_val;
        end else if (stop) begin
          state_nx   = IDLE;
          next_count = '0;
        end else if (start) begin
          state_nx = RUN;
        end
      end
      default: begin
        state_nx   = IDLE;
        next_count = '0;
      end
    endcase
  end

  always_comb begin
    s = '0;
    r = '0;
    for (int i = 0; i < WIDTH; i++)
      {s[i], r[i]} = sr_excite(next_count[i], count[i]);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      tc    <= 1'b0;
    end else begin
      state <= state_nx;
      tc    <= tc_nx;
    end
  end

  assign busy   = (state == RUN);
  assign paused = (state == PAUSE);

  sr_reg_bank #(.WIDTH(WIDTH)) u_bank (
    .clk     (clk),
    .reset_n (reset_n),
    .s       (s),
    .r       (r),
    .q       (count)
  );

`ifdef SR_CTRL_WRAP_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      wrap_cnt <= 8'd0;
    else if (load)
      wrap_cnt <= 8'd0;
    else if (tc_nx && wrap_cnt != 8'hFF)
      wrap_cnt <= wrap_cnt + 8'd1;
  end
`endif

endmodule

// File: doc/sr_counter_ctrl.md
Name: sr_counter_ctrl

Overview:
Programmable up/down modulo counter controller built on an SR flip-flop register bank.
- Sequences the SR bank through start/pause/stop/load commands.
- Computes per-bit S/R excitation from the current state and the next count value.
- Flags terminal-count wrap for downstream timing logic.
- Sits between control logic and the WIDTH-bit SR-flop counter datapath.

Parameters:
WIDTH, 3, counter width in bits (number of SR flip-flops).

Ports:
clk  input  1  system clock, rising edge.
reset_n  input  1  asynchronous, active-low reset.
start  input  1  level command; enter or resume counting.
stop  input  1  level command; pause from RUN, clear from PAUSE.
load  input  1  load load_val into the counter this cycle.
load_val  input  WIDTH  value to load.
dir  input  1  1 = count up, 0 = count down; sampled every cycle.
mod_val  input  WIDTH  terminal value; counter spans 0..mod_val inclusive.
count  output  WIDTH  current counter value (SR bank Q outputs).
busy  output  1  high in RUN.
paused  output  1  high in PAUSE.
tc  output  1  one-cycle pulse, registered, coincident with the wrap value appearing on count.

Behaviour:
- Reset (reset_n low, async): state=IDLE, count=0, tc=0, busy=0, paused=0. All SR flops are cleared through their own async clear.
- States: IDLE=2'd0, RUN=2'd1, PAUSE=2'd2. 2'd3 is illegal and recovers to IDLE with count=0 on the next edge.
- Command priority when several are high in one cycle: load > stop > start.
- IDLE:
  - load: count <= clamp(load_val); stay IDLE.
  - start: go to RUN. The first increment happens on the edge after RUN is entered.
  - stop: no effect.
- RUN: count advances every cycle.
  - Up: next = (count >= mod_val) ? 0 : count+1.
  - Down: next = (count == 0 || count > mod_val) ? mod_val : count-1.
  - tc=1 in the cycle count takes the wrap value (0 when up, mod_val when down).
  - load: count <= clamp(load_val); stay RUN; tc=0 that cycle.
  - stop: go to PAUSE; count holds at its current value.
- PAUSE: count holds.
  - start: go to RUN.
  - stop: go to IDLE with count <= 0.
  - load: count <= clamp(load_val); stay PAUSE.
- clamp(v) = (v > mod_val) ? mod_val : v.
- mod_val == 0: count stays 0; tc pulses every RUN cycle.
- mod_val may change mid-run. An out-of-range count wraps on the next RUN edge per the rules above, with tc asserted.
- dir may change mid-run. The new direction takes effect on the next edge.
- Excitation per bit i, driven into the SR bank:
  - s[i] = next[i] & ~count[i]
  - r[i] = ~next[i] & count[i]
  - Hold when next == count.
  - s[i] & r[i] must never be 1; the illegal SR code is never produced.
- Latency: command sampled at edge N; count/state change is visible after edge N.

Optional Feature:
Macro SR_CTRL_WRAP_CNT_EN.
- Defined: adds output wrap_cnt[7:0].
  - Increments on each tc pulse and saturates at 8'hFF.
  - Clears on reset_n low and on load.
- Undefined: port and logic are absent; all other behaviour is identical.

Decomposition:
- Package sr_ctrl_pkg:
  - State encodings IDLE/RUN/PAUSE.
  - SR code constants SR_HOLD=2'b00, SR_RST=2'b01, SR_SET=2'b10, SR_ILLEGAL=2'b11.
  - Function sr_excite(next_bit, cur_bit) returning {s,r}.
- Sub-module sr_reg_bank: WIDTH SR flip-flops with async active-low clear and vector s/r/q ports. The controller instantiates one.

Test Plan:
- Reset, then start with dir=1, mod_val=5 for 14 cycles -> count 0,1,2,3,4,5,0,1,...; tc high exactly on the two cycles count returns to 0; busy=1.
- dir=0, mod_val=4, load_val=2, load then start -> count 2,1,0,4,3,...; tc on the cycle count=4.
- In RUN at count=3: stop -> PAUSE, count holds 3 for 5 cycles; start -> 4; stop, then stop again -> IDLE, count=0.
- load=1, stop=1, start=1 together in RUN with load_val=7, mod_val=5 -> count=5, state stays RUN, tc=0.
- reset_n low mid-count (count=4) asynchronously, between edges -> count=0, busy=0 immediately; every cycle, checker asserts no bit has s&r=1.
- With SR_CTRL_WRAP_CNT_EN, mod_val=0, run 300 cycles -> wrap_cnt saturates at 255; a load clears it to 0.
